// File: rtl/shape_fetch_if.sv
// Bundle between shape_fetch, the shape RAM read port and the renderer.
// master = shape_fetch side, slave = RAM/renderer/controller side.
interface shape_fetch_if #(
    parameter int ADDRW = 20,
    parameter int DATAW = 12,
    parameter int CORDW = 10,
    parameter int NUMW  = DATAW
);
    logic             start;
    logic [NUMW-1:0]  count;
    logic [ADDRW-1:0] ram_address_offset;
    logic [ADDRW-1:0] ram_address;
    logic             ram_rd_en;
    logic [DATAW-1:0] ram_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [NUMW-1:0]  out_id;
    logic [DATAW-1:0] out_ty;
    logic [CORDW-1:0] out_x;
    logic [CORDW-1:0] out_y;
    logic [DATAW-1:0] out_size;
    logic [DATAW-1:0] out_rotate;
    logic             busy;
    logic             done;

    modport master (
        input  start, count, ram_address_offset, ram_rdata, out_ready,
        output ram_address, ram_rd_en, out_valid, out_id, out_ty, out_x, out_y,
               out_size, out_rotate, busy, done
    );

    modport slave (
        output start, count, ram_address_offset, ram_rdata, out_ready,
        input  ram_address, ram_rd_en, out_valid, out_id, out_ty, out_x, out_y,
               out_size, out_rotate, busy, done
    );
endinterface

// File: rtl/shape_fetch.sv
// Walks shape slots 0..count-1, reads five record words per slot and hands
// each non-empty record to the renderer over valid/ready.
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | five back-to-back reads, ptr 0..4
//   WAIT  | draining read latency until the ptr-4 word is captured
//   EMIT  | record presented (or skipped when type == 0)
module shape_fetch #(
    parameter int DATAB  = 3,
    parameter int CORDW  = 10,
    parameter int ADDRW  = 20,
    parameter int DATAW  = 12,
    parameter int NUMW   = DATAW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    shape_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

    state_t           state, state_nx;
    logic [NUMW-1:0]  id, count_l, id_out;
    logic [ADDRW-1:0] offset_l;
    logic [2:0]       ptr;
    logic             done_r;
    logic [DATAW-1:0] ty_r, size_r, rot_r;
    logic [CORDW-1:0] x_r, y_r;
    logic             tag_v [RD_LAT];
    logic [2:0]       tag_p [RD_LAT];
    logic             cap_v;
    logic [2:0]       cap_p;
    logic             last, advance;

    assign cap_v   = tag_v[RD_LAT-1];
    assign cap_p   = tag_p[RD_LAT-1];
    assign last    = (id == count_l - NUMW'(1));
    assign advance = (ty_r == '0) || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start && bus.count != '0) state_nx = ISSUE;
            ISSUE: if (ptr == 3'd4) state_nx = WAIT;
            WAIT:  if (cap_v && cap_p == 3'd4) state_nx = EMIT;
            EMIT:  if (advance) state_nx = last ? IDLE : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state != IDLE);
        bus.ram_rd_en   = (state == ISSUE);
        bus.out_valid   = (state == EMIT) && (ty_r != '0);
        bus.done        = done_r;
        bus.ram_address = (ADDRW'(id) << DATAB) + offset_l + ADDRW'(ptr);
        bus.out_id      = id_out;
        bus.out_ty      = ty_r;
        bus.out_x       = x_r;
        bus.out_y       = y_r;
        bus.out_size    = size_r;
        bus.out_rotate  = rot_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id       <= '0;
            count_l  <= '0;
            offset_l <= '0;
            ptr      <= '0;
            done_r   <= 1'b0;
            id_out   <= '0;
            ty_r     <= '0;
            x_r      <= '0;
            y_r      <= '0;
            size_r   <= '0;
            rot_r    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_v[i] <= 1'b0;
                tag_p[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    count_l  <= bus.count;
                    offset_l <= bus.ram_address_offset;
                    id       <= '0;
                    ptr      <= '0;
                    done_r   <= (bus.count == '0);
                end
                ISSUE: ptr <= (ptr == 3'd4) ? 3'd0 : ptr + 3'd1;
                WAIT:  id_out <= id;
                EMIT: if (advance) begin
                    ptr <= '0;
                    if (last) done_r <= 1'b1;
                    else      id     <= id + NUMW'(1);
                end
                default: ;
            endcase

            // Tag rides alongside the read so the returning word knows its field.
            tag_v[0] <= (state == ISSUE);
            tag_p[0] <= ptr;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_p[i] <= tag_p[i-1];
            end

            if (cap_v) begin
                case (cap_p)
                    3'd0: ty_r   <= bus.ram_rdata;
                    3'd1: x_r    <= bus.ram_rdata[CORDW-1:0];
                    3'd2: y_r    <= bus.ram_rdata[CORDW-1:0];
                    3'd3: size_r <= bus.ram_rdata;
                    3'd4: rot_r  <= bus.ram_rdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_shape_fetch.sv
// Directed bench for shape_fetch: RD_LAT=1 and RD_LAT=3 instances, each with
// a RAM model and a record scoreboard.
module tb_shape_fetch;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done1 = 0, done3 = 0, emit1 = 0, emit3 = 0;
    logic [127:0] q1[$];
    logic [127:0] q3[$];
    logic [19:0]  log1[$];
    logic [11:0]  mem [0:4095];
    logic [11:0]  p1, p2;

    shape_fetch_if #(.ADDRW(20), .DATAW(12), .CORDW(10), .NUMW(12)) b1 ();
    shape_fetch_if #(.ADDRW(20), .DATAW(12), .CORDW(10), .NUMW(12)) b3 ();

    shape_fetch #(.DATAB(3), .CORDW(10), .ADDRW(20), .DATAW(12), .NUMW(12), .RD_LAT(1))
        d1 (.clk(clk), .rst(rst), .bus(b1.master));
    shape_fetch #(.DATAB(3), .CORDW(10), .ADDRW(20), .DATAW(12), .NUMW(12), .RD_LAT(3))
        d3 (.clk(clk), .rst(rst), .bus(b3.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) b1.ram_rdata <= b1.ram_rd_en ? mem[b1.ram_address[11:0]] : 12'hEEE;
    always @(posedge clk) begin
        p1 <= b3.ram_rd_en ? mem[b3.ram_address[11:0]] : 12'hEEE;
        p2 <= p1;
        b3.ram_rdata <= p2;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pk(input logic [11:0] id, input logic [11:0] ty,
                                        input logic [11:0] x, input logic [11:0] y,
                                        input logic [11:0] sz, input logic [11:0] rot);
        return {60'd0, id, ty, x[9:0], y[9:0], sz, rot};
    endfunction

    task automatic wr_slot(input int base, input int id, input logic [11:0] ty,
                           input logic [11:0] x, input logic [11:0] y,
                           input logic [11:0] sz, input logic [11:0] rot);
        mem[base + id*8 + 0] = ty;
        mem[base + id*8 + 1] = x;
        mem[base + id*8 + 2] = y;
        mem[base + id*8 + 3] = sz;
        mem[base + id*8 + 4] = rot;
    endtask

    // Observe the cycle about to be clocked, then advance to just after the edge.
    task automatic step();
        if (b1.out_valid) begin
            if (q1.size() == 0) chk("d1 valid with empty scoreboard", b1.out_valid, 0);
            else begin
                chk("d1 record", pk(b1.out_id, b1.out_ty, {2'b0, b1.out_x}, {2'b0, b1.out_y},
                                    b1.out_size, b1.out_rotate), q1[0]);
                if (b1.out_ready) begin void'(q1.pop_front()); emit1++; end
            end
        end
        if (b3.out_valid) begin
            if (q3.size() == 0) chk("d3 valid with empty scoreboard", b3.out_valid, 0);
            else begin
                chk("d3 record", pk(b3.out_id, b3.out_ty, {2'b0, b3.out_x}, {2'b0, b3.out_y},
                                    b3.out_size, b3.out_rotate), q3[0]);
                if (b3.out_ready) begin void'(q3.pop_front()); emit3++; end
            end
        end
        chk("d1 done with valid", b1.done & b1.out_valid, 0);
        if (b1.ram_rd_en) log1.push_back(b1.ram_address);
        if (b1.done) done1++;
        if (b3.done) done3++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int which, input string tag, input int budget);
        int d0;
        d0 = (which == 1) ? done1 : done3;
        for (int k = 0; k < budget && ((which == 1) ? done1 : done3) == d0; k++) step();
        chk(tag, ((which == 1) ? done1 : done3) - d0, 1);
    endtask

    initial begin
        int d0, e0;
        for (int i = 0; i < 4096; i++) mem[i] = 12'h0;
        rst = 1'b1;
        b1.start = 0; b1.count = 0; b1.ram_address_offset = 0; b1.out_ready = 1;
        b3.start = 0; b3.count = 0; b3.ram_address_offset = 0; b3.out_ready = 1;
        repeat (3) step();
        chk("reset busy", b1.busy, 0);
        chk("reset rd_en", b1.ram_rd_en, 0);
        chk("reset valid/done", {b1.out_valid, b1.done}, 0);
        chk("reset fields", pk(b1.out_id, b1.out_ty, {2'b0, b1.out_x}, {2'b0, b1.out_y},
                               b1.out_size, b1.out_rotate), 0);
        rst = 1'b0;
        step();

        // single record, exact timing
        wr_slot('h100, 0, 3, 17, 42, 9, 2);
        log1.delete();
        q1.push_back(pk(0, 3, 17, 42, 9, 2));
        b1.count = 1; b1.ram_address_offset = 20'h100; b1.start = 1;
        step();
        b1.start = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t1 rd_en", b1.ram_rd_en, 1);
            chk("t1 addr", b1.ram_address, 128'(32'h100 + i));
            step();
        end
        chk("t1 cycle6 rd_en/valid", {b1.ram_rd_en, b1.out_valid}, 0);
        step();
        chk("t1 cycle7 valid", b1.out_valid, 1);
        chk("t1 cycle7 id", b1.out_id, 0);
        step();
        chk("t1 cycle8 done/valid/busy", {b1.done, b1.out_valid, b1.busy}, 3'b100);
        step();
        chk("t1 done one cycle", b1.done, 0);
        chk("t1 scoreboard empty", q1.size(), 0);

        // empty slot is read but skipped
        wr_slot('h100, 0, 5, 1, 2, 3, 4);
        wr_slot('h100, 1, 0, 7, 7, 7, 7);
        wr_slot('h100, 2, 6, 100, 200, 11, 12);
        q1.push_back(pk(0, 5, 1, 2, 3, 4));
        q1.push_back(pk(2, 6, 100, 200, 11, 12));
        log1.delete(); e0 = emit1; d0 = done1;
        b1.count = 3; b1.start = 1;
        step();
        b1.start = 0;
        wait_done(1, "t2 done", 80);
        repeat (4) step();
        chk("t2 single done", done1 - d0, 1);
        chk("t2 records emitted", emit1 - e0, 2);
        chk("t2 reads", log1.size(), 15);
        for (int i = 0; i < 5; i++) chk("t2 slot1 addr", log1[5 + i], 128'(32'h108 + i));

        // backpressure
        wr_slot('h100, 0, 1, 5, 6, 7, 8);
        wr_slot('h100, 1, 2, 9, 10, 11, 12);
        q1.push_back(pk(0, 1, 5, 6, 7, 8));
        q1.push_back(pk(1, 2, 9, 10, 11, 12));
        b1.out_ready = 0; b1.count = 2; b1.start = 1;
        step();
        b1.start = 0;
        for (int k = 0; k < 20 && !b1.out_valid; k++) step();
        chk("t3 valid reached", b1.out_valid, 1);
        log1.delete();
        for (int k = 0; k < 10; k++) begin
            chk("t3 valid held", b1.out_valid, 1);
            step();
        end
        chk("t3 no reads while stalled", log1.size(), 0);
        b1.out_ready = 1;
        step();
        chk("t3 next issue rd_en", b1.ram_rd_en, 1);
        chk("t3 next issue addr", b1.ram_address, 128'(32'h108));
        wait_done(1, "t3 done", 40);
        chk("t3 scoreboard empty", q1.size(), 0);

        // zero count
        log1.delete(); d0 = done1;
        b1.count = 0; b1.start = 1;
        step();
        b1.start = 0;
        chk("t4 done/busy/rd_en", {b1.done, b1.busy, b1.ram_rd_en}, 3'b100);
        step();
        chk("t4 done/busy after", {b1.done, b1.busy}, 0);
        chk("t4 no reads", log1.size(), 0);

        // RD_LAT=3, upper coordinate bits dropped
        wr_slot('h200, 0, 4, 12'hFFF, 12'hC55, 12'h123, 12'h456);
        wr_slot('h200, 1, 9, 12'h1AB, 12'h2CD, 12'h777, 12'h888);
        q3.push_back(pk(0, 4, 12'hFFF, 12'hC55, 12'h123, 12'h456));
        q3.push_back(pk(1, 9, 12'h1AB, 12'h2CD, 12'h777, 12'h888));
        e0 = emit3;
        b3.count = 2; b3.ram_address_offset = 20'h200; b3.start = 1;
        step();
        b3.start = 0;
        wait_done(3, "t5 done", 80);
        chk("t5 records emitted", emit3 - e0, 2);
        chk("t5 scoreboard empty", q3.size(), 0);

        // reset during ISSUE of id 1
        q1.push_back(pk(0, 1, 5, 6, 7, 8));
        b1.count = 2; b1.ram_address_offset = 20'h100; b1.start = 1;
        step();
        b1.start = 0;
        for (int k = 0; k < 40 && !(b1.ram_rd_en && b1.ram_address == 20'h108); k++) step();
        chk("t6 reached id1 issue", b1.ram_address, 128'(32'h108));
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6 after reset busy/rd_en/valid", {b1.busy, b1.ram_rd_en, b1.out_valid}, 0);
        d0 = done1;
        repeat (12) step();
        chk("t6 no done after reset", done1 - d0, 0);
        chk("t6 scoreboard empty", q1.size(), 0);
        q1.push_back(pk(0, 1, 5, 6, 7, 8));
        b1.count = 1; b1.start = 1;
        step();
        b1.start = 0;
        chk("t6 rescan addr", b1.ram_address, 128'(32'h100));
        chk("t6 rescan rd_en", b1.ram_rd_en, 1);
        wait_done(1, "t6 rescan done", 40);
        chk("t6 rescan scoreboard empty", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
